// File: rtl/vmask_cmp_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : vmask_cmp_pack_if
// Description : Beat-in / packed-mask-word-out bus for the vector compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface vmask_cmp_pack_if #(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
    parameter int REQ_ADDR_WIDTH    = 32,
    parameter int SEW_WIDTH         = 2,
    parameter int OPSEL_WIDTH       = 3,
    parameter int IDX_WIDTH         = $clog2(REQ_DATA_WIDTH)
) ();
    logic                         in_valid;
    logic [REQ_ADDR_WIDTH-1:0]    in_addr;
    logic [REQ_DATA_WIDTH-1:0]    in_vec0;
    logic [REQ_DATA_WIDTH-1:0]    in_vec1;
    logic [SEW_WIDTH-1:0]         in_sew;
    logic [OPSEL_WIDTH-1:0]       in_opSel;
    logic [IDX_WIDTH-1:0]         in_start_idx;
    logic                         in_req_start;
    logic                         in_req_end;
    logic                         in_vm;
    logic [REQ_BYTE_EN_WIDTH-1:0] in_mask;

    logic                         out_valid;
    logic [REQ_ADDR_WIDTH-1:0]    out_addr;
    logic [REQ_DATA_WIDTH-1:0]    out_vec;
    logic [REQ_BYTE_EN_WIDTH-1:0] out_be;

    modport master (
        output in_valid, in_addr, in_vec0, in_vec1, in_sew, in_opSel,
               in_start_idx, in_req_start, in_req_end, in_vm, in_mask,
        input  out_valid, out_addr, out_vec, out_be
    );

    modport slave (
        input  in_valid, in_addr, in_vec0, in_vec1, in_sew, in_opSel,
               in_start_idx, in_req_start, in_req_end, in_vm, in_mask,
        output out_valid, out_addr, out_vec, out_be
    );
endinterface
`default_nettype wire

// File: rtl/vmask_cmp_pack.sv
`default_nettype none
// ============================================================================
// Module      : vmask_cmp_pack
// Description : Element-wise RVV integer compare, packed into mask words.
//               Define VMCMP_MASK_EN to honour in_vm/in_mask.
// Revision    : 1.0 - initial release
// ============================================================================
module vmask_cmp_pack #(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
    parameter int REQ_ADDR_WIDTH    = 32,
    parameter int SEW_WIDTH         = 2,
    parameter int OPSEL_WIDTH       = 3,
    parameter int IDX_WIDTH         = $clog2(REQ_DATA_WIDTH),
    parameter int OUT_STAGES        = 3
) (
    input  wire logic           clk,
    input  wire logic           rst,
    vmask_cmp_pack_if.slave     bus
);

    localparam int c_dw  = REQ_DATA_WIDTH;
    localparam int c_bew = REQ_BYTE_EN_WIDTH;

    // 65-bit compare: unsigned operands are zero-extended, signed sign-extended
    function automatic logic f_cmp(input logic [64:0] a, input logic [64:0] b,
                                   input logic [2:0] op);
        logic eq;
        logic lt;
        logic r;
        eq = (a == b);
        lt = ($signed(a) < $signed(b));
        case (op)
            3'd0:       r = eq;
            3'd1:       r = ~eq;
            3'd2, 3'd3: r = lt;
            3'd4, 3'd5: r = lt | eq;
            default:    r = ~(lt | eq);
        endcase
        return r;
    endfunction

    // ---------------- s0: input register ----------------
    logic                      r0_valid;
    logic [REQ_ADDR_WIDTH-1:0] r0_addr;
    logic [c_dw-1:0]           r0_vec0;
    logic [c_dw-1:0]           r0_vec1;
    logic [SEW_WIDTH-1:0]      r0_sew;
    logic [OPSEL_WIDTH-1:0]    r0_op;
    logic [IDX_WIDTH-1:0]      r0_start;
    logic                      r0_rs;
    logic                      r0_re;
`ifdef VMCMP_MASK_EN
    logic                      r0_vm;
    logic [c_bew-1:0]          r0_mask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid <= 1'b0;
            r0_addr  <= '0;
            r0_vec0  <= '0;
            r0_vec1  <= '0;
            r0_sew   <= '0;
            r0_op    <= '0;
            r0_start <= '0;
            r0_rs    <= 1'b0;
            r0_re    <= 1'b0;
`ifdef VMCMP_MASK_EN
            r0_vm    <= 1'b1;
            r0_mask  <= '0;
`endif
        end else begin
            r0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r0_addr  <= bus.in_addr;
                r0_vec0  <= bus.in_vec0;
                r0_vec1  <= bus.in_vec1;
                r0_sew   <= bus.in_sew;
                r0_op    <= bus.in_opSel;
                r0_start <= bus.in_start_idx;
                r0_rs    <= bus.in_req_start;
                r0_re    <= bus.in_req_end;
`ifdef VMCMP_MASK_EN
                r0_vm    <= bus.in_vm;
                r0_mask  <= bus.in_mask;
`endif
            end
        end
    end

    // ---------------- s1: compare + mask ----------------
    logic                       w_sgn;
    logic [3:0][c_bew-1:0]      w_res_s;
    logic [c_bew-1:0]           w_res;

    assign w_sgn = r0_op[0];

    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int c_w = 8 << s;
        localparam int c_n = c_dw / c_w;
        for (genvar i = 0; i < c_n; i++) begin : g_elem
            logic [64:0] w_a;
            logic [64:0] w_b;
            assign w_a = {{(65-c_w){w_sgn & r0_vec0[i*c_w + c_w - 1]}}, r0_vec0[i*c_w +: c_w]};
            assign w_b = {{(65-c_w){w_sgn & r0_vec1[i*c_w + c_w - 1]}}, r0_vec1[i*c_w +: c_w]};
`ifdef VMCMP_MASK_EN
            // Masked-off elements are agnostic and written as 1
            assign w_res_s[s][i] = f_cmp(w_a, w_b, r0_op[2:0]) | (~r0_vm & ~r0_mask[i]);
`else
            assign w_res_s[s][i] = f_cmp(w_a, w_b, r0_op[2:0]);
`endif
        end
        if (c_n < c_bew) begin : g_pad
            assign w_res_s[s][c_bew-1:c_n] = '0;
        end
    end

    assign w_res = w_res_s[r0_sew];

    logic                      r1_valid;
    logic [REQ_ADDR_WIDTH-1:0] r1_addr;
    logic [c_bew-1:0]          r1_res;
    logic [SEW_WIDTH-1:0]      r1_sew;
    logic [IDX_WIDTH-1:0]      r1_start;
    logic                      r1_rs;
    logic                      r1_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_addr  <= '0;
            r1_res   <= '0;
            r1_sew   <= '0;
            r1_start <= '0;
            r1_rs    <= 1'b0;
            r1_re    <= 1'b0;
        end else begin
            r1_valid <= r0_valid;
            if (r0_valid) begin
                r1_addr  <= r0_addr;
                r1_res   <= w_res;
                r1_sew   <= r0_sew;
                r1_start <= r0_start;
                r1_rs    <= r0_rs;
                r1_re    <= r0_re;
            end
        end
    end

    // ---------------- s2: pack / close ----------------
    logic [c_dw-1:0]  r_acc;
    logic [c_bew-1:0] r_bv;
    logic [IDX_WIDTH:0] w_n;
    logic [IDX_WIDTH:0] w_end;
    logic               w_close;
    logic [c_dw-1:0]    w_word;
    logic [c_bew-1:0]   w_bv_new;
    logic [c_bew-1:0]   w_bv;

    always_comb begin
        w_n      = (IDX_WIDTH+1)'(c_dw >> (32'(r1_sew) + 3));
        w_end    = {1'b0, r1_start} + w_n;
        w_close  = r1_re || (w_end == (IDX_WIDTH+1)'(c_dw));
        w_word   = (r1_rs ? '0 : r_acc)
                 | ({{(c_dw-c_bew){1'b0}}, r1_res} << r1_start);
        w_bv_new = '0;
        for (int j = 0; j < c_bew; j++) begin
            w_bv_new[j] = ((j * 8) < int'(w_end)) && ((j * 8 + 8) > int'(r1_start));
        end
        w_bv     = (r1_rs ? '0 : r_bv) | w_bv_new;
    end

    logic                      r2_valid;
    logic [REQ_ADDR_WIDTH-1:0] r2_addr;
    logic [c_dw-1:0]           r2_vec;
    logic [c_bew-1:0]          r2_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_bv     <= '0;
            r2_valid <= 1'b0;
            r2_addr  <= '0;
            r2_vec   <= '0;
            r2_be    <= '0;
        end else begin
            r2_valid <= r1_valid && w_close;
            if (r1_valid) begin
                if (w_close) begin
                    r_acc   <= '0;
                    r_bv    <= '0;
                    r2_addr <= r1_addr;
                    r2_vec  <= w_word;
                    r2_be   <= w_bv;
                end else begin
                    r_acc   <= w_word;
                    r_bv    <= w_bv;
                end
            end
        end
    end

    // ---------------- latency-matching output stages ----------------
    if (OUT_STAGES == 0) begin : g_out_direct
        assign bus.out_valid = r2_valid;
        assign bus.out_addr  = r2_addr;
        assign bus.out_vec   = r2_vec;
        assign bus.out_be    = r2_be;
    end else begin : g_out_pipe
        logic                      r_pv [OUT_STAGES];
        logic [REQ_ADDR_WIDTH-1:0] r_pa [OUT_STAGES];
        logic [c_dw-1:0]           r_pd [OUT_STAGES];
        logic [c_bew-1:0]          r_pb [OUT_STAGES];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < OUT_STAGES; k++) begin
                    r_pv[k] <= 1'b0;
                    r_pa[k] <= '0;
                    r_pd[k] <= '0;
                    r_pb[k] <= '0;
                end
            end else begin
                r_pv[0] <= r2_valid;
                r_pa[0] <= r2_addr;
                r_pd[0] <= r2_vec;
                r_pb[0] <= r2_be;
                for (int k = 1; k < OUT_STAGES; k++) begin
                    r_pv[k] <= r_pv[k-1];
                    r_pa[k] <= r_pa[k-1];
                    r_pd[k] <= r_pd[k-1];
                    r_pb[k] <= r_pb[k-1];
                end
            end
        end

        assign bus.out_valid = r_pv[OUT_STAGES-1];
        assign bus.out_addr  = r_pa[OUT_STAGES-1];
        assign bus.out_vec   = r_pd[OUT_STAGES-1];
        assign bus.out_be    = r_pb[OUT_STAGES-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_vmask_cmp_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmask_cmp_pack
// Description : Directed self-checking bench for vmask_cmp_pack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmask_cmp_pack;

    localparam int c_dw  = 64;
    localparam int c_bew = 8;
    localparam int c_aw  = 32;
`ifdef VMCMP_MASK_EN
    localparam logic [63:0] c_mask_exp = 64'hA;
`else
    localparam logic [63:0] c_mask_exp = 64'h0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   pulses      = 0;
    int   p0;

    always #5 clk = ~clk;

    vmask_cmp_pack_if #(.REQ_DATA_WIDTH(c_dw), .REQ_BYTE_EN_WIDTH(c_bew),
                        .REQ_ADDR_WIDTH(c_aw)) bus ();

    vmask_cmp_pack #(.REQ_DATA_WIDTH(c_dw), .REQ_BYTE_EN_WIDTH(c_bew),
                     .REQ_ADDR_WIDTH(c_aw), .OUT_STAGES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.out_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_addr      = '0;
        bus.in_vec0      = '0;
        bus.in_vec1      = '0;
        bus.in_sew       = '0;
        bus.in_opSel     = '0;
        bus.in_start_idx = '0;
        bus.in_req_start = 1'b0;
        bus.in_req_end   = 1'b0;
        bus.in_vm        = 1'b1;
        bus.in_mask      = '0;
    endtask

    task automatic beat(input logic [31:0] addr, input logic [63:0] v0, input logic [63:0] v1,
                        input logic [1:0] sew, input logic [2:0] op, input logic [5:0] st,
                        input logic rs, input logic re, input logic vm, input logic [7:0] mask);
        bus.in_valid     = 1'b1;
        bus.in_addr      = addr;
        bus.in_vec0      = v0;
        bus.in_vec1      = v1;
        bus.in_sew       = sew;
        bus.in_opSel     = op;
        bus.in_start_idx = st;
        bus.in_req_start = rs;
        bus.in_req_end   = re;
        bus.in_vm        = vm;
        bus.in_mask      = mask;
        @(negedge clk);
        idle();
    endtask

    // Called right after the closing beat: checks exact latency and single pulse
    task automatic expect_word(input string tag, input logic [31:0] addr,
                               input logic [63:0] vec, input logic [7:0] be);
        repeat (4) @(negedge clk);
        check({tag, "_early"}, 64'(bus.out_valid), 64'h0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'h1);
        check({tag, "_vec"},   bus.out_vec, vec);
        check({tag, "_be"},    64'(bus.out_be), 64'(be));
        check({tag, "_addr"},  64'(bus.out_addr), 64'(addr));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.out_valid), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_vec",   bus.out_vec, 64'h0);
        check("rst_be",    64'(bus.out_be), 64'h0);
        check("rst_addr",  64'(bus.out_addr), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset with two beats in flight; the second would otherwise close a word
        p0 = pulses;
        beat(32'h80, 64'h1111, 64'h1111, 2'd0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b1, 8'h0);
        beat(32'h81, 64'h2222, 64'h2222, 2'd0, 3'd0, 6'd8, 1'b0, 1'b1, 1'b1, 8'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstmid_pulses", 64'(pulses - p0), 64'h0);
        check("rstmid_be",     64'(bus.out_be), 64'h0);

        // SEW=8, eight equal beats filling one word
        p0 = pulses;
        for (int k = 0; k < 8; k++) begin
            v = 64'h0123_4567_89AB_CDEF ^ 64'(k);
            beat(32'h100 + 32'(k), v, v, 2'd0, 3'd0, 6'(k * 8), (k == 0), 1'b0, 1'b1, 8'h0);
        end
        expect_word("full8", 32'h107, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        @(negedge clk);
        check("full8_count", 64'(pulses - p0), 64'h1);

        // SEW=64 signed lt: most-negative < 1
        beat(32'h200, 64'h8000_0000_0000_0000, 64'h1, 2'd3, 3'd3, 6'd0, 1'b1, 1'b1, 1'b1, 8'h0);
        expect_word("lt64", 32'h200, 64'h1, 8'h01);

        // SEW=32 ltu then gtu back-to-back
        beat(32'h300, {32'd5, 32'd1}, {32'd3, 32'd2}, 2'd2, 3'd2, 6'd0, 1'b1, 1'b1, 1'b1, 8'h0);
        beat(32'h304, {32'd5, 32'd1}, {32'd3, 32'd2}, 2'd2, 3'd6, 6'd0, 1'b1, 1'b1, 1'b1, 8'h0);
        repeat (4) @(negedge clk);
        check("ltu32_valid", 64'(bus.out_valid), 64'h1);
        check("ltu32_vec",   bus.out_vec, 64'h1);
        check("ltu32_be",    64'(bus.out_be), 64'h01);
        @(negedge clk);
        check("gtu32_valid", 64'(bus.out_valid), 64'h1);
        check("gtu32_vec",   bus.out_vec, 64'h2);
        check("gtu32_addr",  64'(bus.out_addr), 64'h304);
        @(negedge clk);

        // SEW=16 masked eq with all elements unequal
        beat(32'h400, 64'h0004_0003_0002_0001, 64'h1004_1003_1002_1001, 2'd1, 3'd0, 6'd0,
             1'b1, 1'b1, 1'b0, 8'b0101);
        expect_word("mask16", 32'h400, c_mask_exp, 8'h01);

        // req_start mid-word discards the stale partial word
        v = 64'hA5A5_5A5A_0F0F_F0F0;
        beat(32'h500, v, v, 2'd0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b1, 8'h0);
        beat(32'h508, v, v ^ 64'h0000_0000_0101_0101, 2'd0, 3'd1, 6'd0, 1'b1, 1'b1, 1'b1, 8'h0);
        expect_word("restart", 32'h508, 64'h0F, 8'h01);

        // Partial word of three SEW=8 beats closed by req_end
        beat(32'h600, v, v, 2'd0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b1, 8'h0);
        beat(32'h608, v, v, 2'd0, 3'd1, 6'd8, 1'b0, 1'b0, 1'b1, 8'h0);
        beat(32'h610, 64'h0, 64'h0101_0101_0101_0101, 2'd0, 3'd2, 6'd16, 1'b0, 1'b1, 1'b1, 8'h0);
        expect_word("partial", 32'h610, 64'hFF_00FF, 8'h07);

        // SEW=8 signed gt vs zero
        beat(32'h700, 64'h807F_00FF_0180_7FFE, 64'h0, 2'd0, 3'd7, 6'd0, 1'b1, 1'b1, 1'b1, 8'h0);
        expect_word("gt8", 32'h700, 64'h4A, 8'h01);

        // SEW=8 leu vs zero placed at bit offset 8
        beat(32'h710, 64'h807F_00FF_0180_7FFE, 64'h0, 2'd0, 3'd4, 6'd8, 1'b1, 1'b1, 1'b1, 8'h0);
        expect_word("leu8", 32'h710, 64'h2000, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
